data_ram_resp: RTL and testbench

Word-addressed data-memory responder that services the load/store requests issued by the MEM stage (`mem_addr`, `mem_we`, `mem_data`). It holds a synchronous word RAM behind a request/ready handshake with a fixed, parameterised access latency, so the multi-cycle control unit can stall MEM until the access completes. It flags misaligned and out-of-range accesses instead of performing them. It sits between MEM and the data-memory model in the top level.

---
 rtl/data_ram_resp.sv | 120 ++++++++++++
 tb/tb_data_ram_resp.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_resp.sv
// Word-addressed data RAM behind a request/ready handshake with a fixed access latency.
// Misaligned or out-of-range requests complete with an error pulse and never touch the RAM.
module data_ram_resp #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_req_i,
  input  logic [31:0] mem_addr_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ready_o,
  output logic        mem_err_o,
  output logic        busy_o
);

  localparam int          DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                  state_reg, state_next;
  logic [3:0]              cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0]   idx_reg;
  logic [31:0]             wdata_reg;
  logic                    we_reg;
  logic                    err_reg;
  logic [31:0]             rdata_reg;
  logic                    ready_reg;
  logic                    err_out_reg;
  logic                    busy_reg;

  logic [31:0]             ram [DEPTH];

  logic                    addr_bad;
  logic                    commit;

  // Reject byte-misaligned addresses and anything above the RAM's word range.
  assign addr_bad = (mem_addr_i[1:0] != 2'b00) || ((mem_addr_i >> (ADDR_WIDTH + 2)) != 32'd0);
  assign commit   = (state_reg == ST_WAIT) && (cnt_reg == 4'd0);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (mem_req_i) begin
          if (addr_bad) begin
            state_next = ST_RESP;
          end else begin
            cnt_next   = CNT_LOAD;
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_reg != 4'd0) begin
          cnt_next = 4'(cnt_reg - 4'd1);
        end else begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= 4'd0;
      idx_reg     <= '0;
      wdata_reg   <= 32'd0;
      we_reg      <= 1'b0;
      err_reg     <= 1'b0;
      rdata_reg   <= 32'd0;
      ready_reg   <= 1'b0;
      err_out_reg <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      busy_reg    <= (state_next != ST_IDLE);
      // The completion pulse is the registered image of the RESP state.
      ready_reg   <= (state_reg == ST_RESP);
      err_out_reg <= (state_reg == ST_RESP) && err_reg;
      if (state_reg == ST_IDLE && mem_req_i) begin
        idx_reg   <= mem_addr_i[ADDR_WIDTH+1:2];
        wdata_reg <= mem_data_i;
        we_reg    <= mem_we_i;
        err_reg   <= addr_bad;
      end
      if (commit && !we_reg) begin
        rdata_reg <= ram[idx_reg];
      end
      if (state_reg == ST_RESP && err_reg) begin
        rdata_reg <= 32'd0;
      end
    end
  end

  // RAM array kept free of reset so it maps onto block RAM; reset still blocks the commit.
  always_ff @(posedge clk) begin
    if (!resetn && commit && we_reg) begin
      ram[idx_reg] <= wdata_reg;
    end
  end

  assign mem_data_o  = rdata_reg;
  assign mem_ready_o = ready_reg;
  assign mem_err_o   = err_out_reg;
  assign busy_o      = busy_reg;

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed bench for data_ram_resp (ADDR_WIDTH = 10, LATENCY = 2) with hand-computed expectations.
module tb_data_ram_resp;

  logic        clk;
  logic        resetn;
  logic        mem_req_i;
  logic [31:0] mem_addr_i;
  logic        mem_we_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_ready_o;
  logic        mem_err_o;
  logic        busy_o;

  int n_checks;
  int n_pass;

  data_ram_resp #(
    .ADDR_WIDTH(10),
    .LATENCY   (2)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .mem_req_i  (mem_req_i),
    .mem_addr_i (mem_addr_i),
    .mem_we_i   (mem_we_i),
    .mem_data_i (mem_data_i),
    .mem_data_o (mem_data_o),
    .mem_ready_o(mem_ready_o),
    .mem_err_o  (mem_err_o),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // One handshake: edges counts rising edges from acceptance until ready is seen (-1 on timeout).
  task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d,
                        output int edges, output logic err, output logic [31:0] rd,
                        output logic busy1, output logic ready_after);
    @(negedge clk);
    mem_req_i  = 1'b1;
    mem_addr_i = a;
    mem_we_i   = w;
    mem_data_i = d;
    edges = -1;
    err   = 1'b0;
    rd    = 32'd0;
    busy1 = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) busy1 = busy_o;
      if (mem_ready_o) begin
        edges = n - 1;
        err   = mem_err_o;
        rd    = mem_data_o;
        break;
      end
    end
    mem_req_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ready_after = mem_ready_o;
    $display("txn addr=0x%08h we=%0b wdata=0x%08h edges=%0d err=%0b rdata=0x%08h",
             a, w, d, edges, err, rd);
  endtask

  task automatic wait_ready(output int n_out);
    n_out = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_ready_o) begin
        n_out = n;
        break;
      end
    end
  endtask

  initial begin
    int          edges;
    int          nw;
    int          ready_seen;
    logic        err;
    logic [31:0] rd;
    logic        busy1;
    logic        rdy_after;

    n_checks   = 0;
    n_pass     = 0;
    resetn     = 1'b1;
    mem_req_i  = 1'b1;
    mem_addr_i = 32'h0000_0010;
    mem_we_i   = 1'b1;
    mem_data_i = 32'hFFFF_FFFF;

    // Reset held with a pending request.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(mem_ready_o), 32'd0);
    chk("rst_err",   32'(mem_err_o),   32'd0);
    chk("rst_busy",  32'(busy_o),      32'd0);
    chk("rst_data",  mem_data_o,       32'd0);
    $display("txn reset held 2 cycles with request high");
    mem_req_i = 1'b0;
    resetn    = 1'b0;

    // Store then load at 0x10.
    access(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, edges, err, rd, busy1, rdy_after);
    chk("wr_latency", 32'(edges), 32'd3);
    chk("wr_err",     32'(err),   32'd0);
    chk("wr_data_o",  rd,         32'd0);
    chk("wr_busy",    32'(busy1), 32'd1);
    chk("wr_pulse",   32'(rdy_after), 32'd0);

    access(32'h0000_0010, 1'b0, 32'h0, edges, err, rd, busy1, rdy_after);
    chk("rd_latency", 32'(edges), 32'd3);
    chk("rd_err",     32'(err),   32'd0);
    chk("rd_data",    rd,         32'hDEAD_BEEF);

    // Misaligned store must not disturb the word at 0x4.
    access(32'h0000_0004, 1'b1, 32'hCAFE_F00D, edges, err, rd, busy1, rdy_after);
    chk("prep4_latency", 32'(edges), 32'd3);
    access(32'h0000_0006, 1'b1, 32'h1234_5678, edges, err, rd, busy1, rdy_after);
    chk("mis_latency", 32'(edges), 32'd1);
    chk("mis_err",     32'(err),   32'd1);
    chk("mis_data",    rd,         32'd0);
    chk("mis_pulse",   32'(rdy_after), 32'd0);
    access(32'h0000_0004, 1'b0, 32'h0, edges, err, rd, busy1, rdy_after);
    chk("rd4_err",  32'(err), 32'd0);
    chk("rd4_data", rd,       32'hCAFE_F00D);

    // Out-of-range loads.
    access(32'h0000_1000, 1'b0, 32'h0, edges, err, rd, busy1, rdy_after);
    chk("oor_latency", 32'(edges), 32'd1);
    chk("oor_err",     32'(err),   32'd1);
    chk("oor_data",    rd,         32'd0);
    access(32'h8000_0010, 1'b0, 32'h0, edges, err, rd, busy1, rdy_after);
    chk("oor_hi_err", 32'(err), 32'd1);

    // Held request: two back-to-back loads.
    @(negedge clk);
    mem_req_i  = 1'b1;
    mem_addr_i = 32'h0000_0010;
    mem_we_i   = 1'b0;
    wait_ready(nw);
    chk("held1_wait", 32'(nw),   32'd4);
    chk("held1_data", mem_data_o, 32'hDEAD_BEEF);
    chk("held_gap_busy", 32'(busy_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("held_reaccept_busy", 32'(busy_o), 32'd1);
    wait_ready(nw);
    chk("held2_wait", 32'(nw),    32'd3);
    chk("held2_data", mem_data_o, 32'hDEAD_BEEF);
    mem_req_i = 1'b0;
    $display("txn held request: two loads of 0x00000010");

    // Reset lands on the commit edge of a store.
    access(32'h0000_0000, 1'b1, 32'h1111_1111, edges, err, rd, busy1, rdy_after);
    chk("prep0_latency", 32'(edges), 32'd3);
    @(negedge clk);
    mem_req_i  = 1'b1;
    mem_addr_i = 32'h0000_0000;
    mem_we_i   = 1'b1;
    mem_data_i = 32'hA5A5_A5A5;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    resetn    = 1'b1;
    mem_req_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    ready_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_ready_o) ready_seen++;
    end
    chk("abort_ready", 32'(ready_seen), 32'd0);
    chk("abort_busy",  32'(busy_o),     32'd0);
    $display("txn store 0xa5a5a5a5 to 0x00000000 aborted by reset");
    access(32'h0000_0000, 1'b0, 32'h0, edges, err, rd, busy1, rdy_after);
    chk("abort_rd_err",  32'(err), 32'd0);
    chk("abort_rd_data", rd,       32'h1111_1111);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
